// File: rtl/memory_arbiter_pkg.sv
// Shared types for the memory_unit arbiter: access flag, arbiter states, and the
// round-robin winner pick.
package memory_arbiter_pkg;

  localparam int REGSIZE = 8;

  typedef enum logic {
    MEM_READ  = 1'b0,
    MEM_WRITE = 1'b1
  } MEMORY_FLAG_TYPE;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } ARB_STATE_TYPE;

  // Returns the winning port id; on a tie the port that did not win last time goes.
  function automatic logic rr_pick(input logic req0, input logic req1, input logic last);
    if (req0 && req1) return ~last;
    return req1;
  endfunction

endpackage

// File: rtl/memory_arbiter_if.sv
// Requester and memory-side signals of the arbiter. The slave modport is the arbiter's
// view; the master modport is the requesters plus memory_unit.
interface memory_arbiter_if
  import memory_arbiter_pkg::*;
#(
  parameter int DATA_W = REGSIZE,
  parameter int ADDR_W = REGSIZE
);

  logic              req0;
  MEMORY_FLAG_TYPE   rw0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              ack0;
  logic [DATA_W-1:0] rdata0;

  logic              req1;
  MEMORY_FLAG_TYPE   rw1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              ack1;
  logic [DATA_W-1:0] rdata1;

  MEMORY_FLAG_TYPE   mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req0, rw0, addr0, wdata0,
    input  req1, rw1, addr1, wdata1,
    input  mem_rdata,
    output ack0, rdata0, ack1, rdata1,
    output mem_rw, mem_addr, mem_wdata
  );

  modport master (
    output req0, rw0, addr0, wdata0,
    output req1, rw1, addr1, wdata1,
    output mem_rdata,
    input  ack0, rdata0, ack1, rdata1,
    input  mem_rw, mem_addr, mem_wdata
  );

endinterface

// File: rtl/memory_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of the single-port memory_unit.
// One access at a time: IDLE -> ACCESS (write 1 cycle, read MEM_LAT cycles) -> RESP.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int DATA_W  = REGSIZE,
  parameter int ADDR_W  = REGSIZE,
  parameter int MEM_LAT = 1
) (
  input  logic                    CLOCK,
  input  logic                    RESET,
  memory_arbiter_if.slave         bus,
  output logic                    busy
);

  localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);

  ARB_STATE_TYPE     state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              last_q, last_d;
  logic              gnt_q, gnt_d;
  logic              win;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  MEMORY_FLAG_TYPE   mem_rw_q, mem_rw_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  assign win = rr_pick(bus.req0, bus.req1, last_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    ack0_d      = ack0_q;
    ack1_d      = ack1_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    mem_rw_d    = mem_rw_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          gnt_d   = win;
          last_d  = win;
          cnt_d   = '0;
          state_d = ACCESS;
          if (win) begin
            mem_rw_d    = bus.rw1;
            mem_addr_d  = bus.addr1;
            mem_wdata_d = bus.wdata1;
          end else begin
            mem_rw_d    = bus.rw0;
            mem_addr_d  = bus.addr0;
            mem_wdata_d = bus.wdata0;
          end
        end
      end
      ACCESS: begin
        // mem_rw_q is MEM_WRITE only during the single write cycle, so it marks the access type.
        if (mem_rw_q == MEM_WRITE) begin
          mem_rw_d = MEM_READ;
          ack0_d   = ~gnt_q;
          ack1_d   = gnt_q;
          state_d  = RESP;
        end else if (cnt_q == LAST_CNT) begin
          if (gnt_q) rdata1_d = bus.mem_rdata;
          else       rdata0_d = bus.mem_rdata;
          ack0_d  = ~gnt_q;
          ack1_d  = gnt_q;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESP: begin
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_q      <= 1'b1;
      gnt_q       <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      busy_q      <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      mem_rw_q    <= MEM_READ;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      busy_q      <= busy_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      mem_rw_q    <= mem_rw_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;
  assign bus.mem_rw    = mem_rw_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign busy          = busy_q;

endmodule
